// File: rtl/mux_nx1_reg.sv
// Registered N-to-1 word multiplexer with valid/ready on every input channel and on the output.
// Define MUX_RR_EN to add the `mode` port and round-robin arbitration; otherwise select is fixed by ctrl.
module mux_nx1_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   ctrl,
`ifdef MUX_RR_EN
  input  logic               mode,
`endif
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   S,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel
);

  logic               accept;
  logic               grant_ok;
  logic               xfer;
  logic [SEL_W-1:0]   grant;
  logic [WIDTH-1:0]   grant_data;

  // The register can take a new word when empty or when it drains this same cycle.
  assign accept = !out_valid || out_ready;

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] last;
  logic             rr_ok;
  logic [SEL_W-1:0] rr_grant;
  logic [SEL_W-1:0] rr_idx;

  // First valid channel found searching upward from last+1, wrapping at N-1.
  always_comb begin
    rr_ok    = 1'b0;
    rr_grant = '0;
    rr_idx   = '0;
    for (int i = 0; i < N; i++) begin
      rr_idx = SEL_W'((int'(last) + 1 + i) % N);
      if (!rr_ok && in_valid[rr_idx]) begin
        rr_ok    = 1'b1;
        rr_grant = rr_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= SEL_W'(N - 1);
    end else if (xfer) begin
      last <= grant;
    end
  end
`endif

  always_comb begin
    grant    = ctrl;
    grant_ok = (int'(ctrl) < N);
`ifdef MUX_RR_EN
    if (mode) begin
      grant    = rr_grant;
      grant_ok = rr_ok;
    end
`endif
  end

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int k = 0; k < N; k++) begin
      if (SEL_W'(k) == grant) begin
        in_ready[k] = grant_ok && accept;
        grant_data  = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  // A transfer overwrites the held word; otherwise a drain simply empties the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S         <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      S         <= grant_data;
      out_sel   <= grant;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Self-checking bench for mux_nx1_reg: table-driven fixed-select vectors, an N=3 out-of-range instance,
// and hand-written reset and round-robin sequences (the latter only when MUX_RR_EN is defined).
module tb_mux_nx1_reg;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [SW-1:0]   ctrl;
`ifdef MUX_RR_EN
  logic            mode;
`endif
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    s;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_sel;

  logic [1:0]      ctrl3;
  logic [3*W-1:0]  in_data3;
  logic [2:0]      in_valid3;
  logic [2:0]      in_ready3;
  logic [W-1:0]    s3;
  logic            out_valid3;
  logic            out_ready3;
  logic [1:0]      out_sel3;

  int checks = 0;
  int fails  = 0;

  mux_nx1_reg #(.WIDTH(W), .N(N), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl),
`ifdef MUX_RR_EN
    .mode(mode),
`endif
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .S(s), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
  );

  mux_nx1_reg #(.WIDTH(W), .N(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .ctrl(ctrl3),
`ifdef MUX_RR_EN
    .mode(1'b0),
`endif
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .S(s3), .out_valid(out_valid3), .out_ready(out_ready3), .out_sel(out_sel3)
  );

  typedef struct {
    logic [1:0]  ctrl;
    logic [3:0]  valid;
    logic [31:0] d0, d1, d2, d3;
    logic        rdy;
    logic [3:0]  exp_ir;
    logic        exp_ov;
    logic [31:0] exp_s;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t vecs[13];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    ctrl      = v.ctrl;
    in_valid  = v.valid;
    in_data   = {v.d3, v.d2, v.d1, v.d0};
    out_ready = v.rdy;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // ctrl, valid, d0, d1, d2, d3, rdy, exp_ir, exp_ov, exp_s, exp_sel
    vecs[0]  = '{2'd2, 4'b0100, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1, 4'b0100, 1'b1, 32'hDEADBEEF, 2'd2};
    vecs[1]  = '{2'd0, 4'b0001, 32'd1, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0001, 1'b1, 32'd1, 2'd0};
    vecs[2]  = '{2'd0, 4'b0001, 32'd2, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0001, 1'b1, 32'd2, 2'd0};
    vecs[3]  = '{2'd0, 4'b0001, 32'd3, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0001, 1'b1, 32'd3, 2'd0};
    vecs[4]  = '{2'd0, 4'b0001, 32'd4, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0001, 1'b1, 32'd4, 2'd0};
    vecs[5]  = '{2'd1, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0010, 1'b0, 32'd4, 2'd0};
    vecs[6]  = '{2'd3, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h12345678, 1'b0, 4'b1000, 1'b1, 32'h12345678, 2'd3};
    vecs[7]  = '{2'd1, 4'b0010, 32'h0, 32'hAAAA0001, 32'h0, 32'h0, 1'b0, 4'b0000, 1'b1, 32'h12345678, 2'd3};
    vecs[8]  = '{2'd1, 4'b0010, 32'h0, 32'hAAAA0002, 32'h0, 32'h0, 1'b0, 4'b0000, 1'b1, 32'h12345678, 2'd3};
    vecs[9]  = '{2'd1, 4'b0010, 32'h0, 32'hAAAA0003, 32'h0, 32'h0, 1'b0, 4'b0000, 1'b1, 32'h12345678, 2'd3};
    vecs[10] = '{2'd1, 4'b0010, 32'h0, 32'hAAAA0004, 32'h0, 32'h0, 1'b1, 4'b0010, 1'b1, 32'hAAAA0004, 2'd1};
    vecs[11] = '{2'd1, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0010, 1'b0, 32'hAAAA0004, 2'd1};
    vecs[12] = '{2'd2, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 4'b0100, 1'b0, 32'hAAAA0004, 2'd1};

    rst        = 1'b1;
    ctrl       = 2'd2;
`ifdef MUX_RR_EN
    mode       = 1'b0;
`endif
    in_data    = '0;
    in_valid   = '0;
    out_ready  = 1'b0;
    ctrl3      = 2'd0;
    in_data3   = '0;
    in_valid3  = '0;
    out_ready3 = 1'b0;

    #12;
    check_output("reset out_valid", 32'(out_valid), 32'd0);
    check_output("reset S", s, 32'd0);
    check_output("reset out_sel", 32'(out_sel), 32'd0);
    check_output("reset in_ready", 32'(in_ready), 32'b0100);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check_output($sformatf("vec%0d S", i), s, vecs[i].exp_s);
      check_output($sformatf("vec%0d out_sel", i), 32'(out_sel), 32'(vecs[i].exp_sel));
    end

    // Reset while a word is held: the word is dropped.
    @(negedge clk);
    ctrl = 2'd0; in_valid = 4'b0001; in_data = {96'h0, 32'h55}; out_ready = 1'b0;
    @(posedge clk);
    #1;
    check_output("preload S", s, 32'h55);
    @(negedge clk);
    rst = 1'b1; in_valid = '0;
    #1;
    check_output("midreset out_valid", 32'(out_valid), 32'd0);
    check_output("midreset S", s, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // N=3 instance: ctrl=3 grants nothing.
    ctrl3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    in_data3 = {32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output($sformatf("oor%0d in_ready", i), 32'(in_ready3), 32'd0);
      @(posedge clk);
      #1;
      check_output($sformatf("oor%0d out_valid", i), 32'(out_valid3), 32'd0);
      @(negedge clk);
    end
    ctrl3 = 2'd2;
    #1;
    check_output("n3 ch2 in_ready", 32'(in_ready3), 32'b100);
    @(posedge clk);
    #1;
    check_output("n3 ch2 S", s3, 32'hC2C2C2C2);
    check_output("n3 ch2 out_sel", 32'(out_sel3), 32'd2);

`ifdef MUX_RR_EN
    begin
      logic [1:0] exp_fair[6];
      logic [1:0] exp_skip[3];
      exp_fair = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      exp_skip = '{2'd1, 2'd3, 2'd1};

      pulse_reset();
      mode = 1'b1; ctrl = 2'd3; out_ready = 1'b1; in_valid = 4'b1111;
      in_data = {32'h103, 32'h102, 32'h101, 32'h100};
      for (int i = 0; i < 6; i++) begin
        @(posedge clk);
        #1;
        check_output($sformatf("rr fair%0d out_sel", i), 32'(out_sel), 32'(exp_fair[i]));
        check_output($sformatf("rr fair%0d S", i), s, 32'h100 + 32'(exp_fair[i]));
      end

      pulse_reset();
      in_valid = 4'b1010;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk);
        #1;
        check_output($sformatf("rr skip%0d out_sel", i), 32'(out_sel), 32'(exp_skip[i]));
      end

      // Stalled output: pointer must not advance past channel 1.
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      check_output("rr stall in_ready", 32'(in_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check_output("rr stall out_sel", 32'(out_sel), 32'd1);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_output("rr resume out_sel", 32'(out_sel), 32'd3);

      pulse_reset();
      in_valid = 4'b1111;
      @(posedge clk);
      #1;
      check_output("rr after reset out_sel", 32'(out_sel), 32'd0);
      check_output("rr after reset out_valid", 32'(out_valid), 32'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mux_nx1_reg.md
# mux_nx1_reg

Parametrised, registered N-to-1 word multiplexer with valid/ready handshaking on every input channel and on the output. It generalises the datapath 4:1 selector to any width and channel count. It adds an output holding register and an optional round-robin arbitration mode. It sits between multi-source producers (ALU result, memory read data, PC+4, immediate path) and a single pipeline-stage consumer that may stall.

## Interface
- `WIDTH`, 32, data width of each channel and of the output.
- `N`, 4, number of input channels (2..16).
- `SEL_W`, 2, select width; must equal ceil(log2(N)).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `ctrl` input SEL_W: channel select in fixed mode.
- `mode` input 1: 0 = fixed select, 1 = round-robin. Present only when `MUX_RR_EN` is defined.
- `in_data` input N*WIDTH: channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
- `in_valid` input N: per-channel valid.
- `in_ready` output N: per-channel ready; at most one bit is high in any cycle.
- `S` output WIDTH: registered output word.
- `out_valid` output 1: S holds an unconsumed word.
- `out_ready` input 1: the consumer accepts S this cycle.
- `out_sel` output SEL_W: index of the channel that supplied S.

## Operation
- A single-entry output register holds S, out_sel and out_valid.
- `accept = !out_valid || out_ready`. A new word can load when the register is empty or is draining in the same cycle.
- A transfer on channel k occurs when `in_valid[k] && in_ready[k]`. On a transfer:
  - S ← channel k data.
  - out_sel ← k.
  - out_valid ← 1.
- With no transfer: if out_ready is high, out_valid ← 0. S and out_sel keep their values.
- Fixed mode (mode=0, or macro absent):
  - The granted channel g is ctrl.
  - in_ready[g] = accept. All other in_ready bits are 0.
  - in_ready is independent of in_valid[g].
  - If ctrl ≥ N, no channel is granted and in_ready is all 0.
- Round-robin mode (mode=1):
  - A pointer `last` holds the index of the most recently transferred channel.
  - The granted channel is the first k with in_valid[k] set, searching from last+1 upward and wrapping at N-1 → 0.
  - in_ready[g] = accept, and only when some channel is valid. ctrl is ignored.
  - `last` updates only on a transfer. A stalled grant does not advance the pointer.
- Output stability: while out_valid=1 and out_ready=0, S and out_sel must not change.
- Mode or ctrl changes while the register is full do not affect the held word. They take effect at the next accept.
- Reset mid-operation clears any held word. That word is lost; no handshake completes.

## Timing
- Reset values:
  - out_valid = 0, S = 0, out_sel = 0.
  - `last` = N-1, so channel 0 has first priority.
  - in_ready follows the combinational rules (accept=1 after reset).
- Latency: 1 cycle. A transfer at edge t gives out_valid=1 and S valid after edge t.
- Throughput: 1 word per cycle when out_ready is held high.
- in_ready depends combinationally on out_valid, out_ready, ctrl, mode and in_valid. It has no dependence on in_data.
- Simultaneous drain and load in one cycle is a legal back-to-back transfer. out_valid stays 1 and S takes the new word.

## Configuration
- `MUX_RR_EN` defined:
  - The `mode` port, the round-robin pointer and the arbitration logic exist.
  - Behaviour is as above.
- `MUX_RR_EN` undefined:
  - The `mode` port, the `last` pointer and the arbitration logic are removed.
  - The block always operates in fixed mode.

## Test plan
- Reset and fixed select:
  - Stimulus: assert rst; release; N=4, WIDTH=32, ctrl=2, ch2 data=0xDEADBEEF, in_valid=4'b0100, out_ready=1.
  - Response: during rst, out_valid=0 and S=0. One cycle after release, S=0xDEADBEEF, out_sel=2, out_valid=1, in_ready=4'b0100.
- Backpressure hold:
  - Stimulus: fill the register with 0x12345678, then out_ready=0 for 3 cycles while ctrl changes to 1 and ch1 data changes.
  - Response: S stays 0x12345678, in_ready=0 throughout. The first cycle after out_ready=1 loads ch1 data.
- Back-to-back streaming:
  - Stimulus: ctrl=0; ch0 presents 1,2,3,4 on consecutive cycles; out_ready=1.
  - Response: S = 1,2,3,4 on consecutive cycles with out_valid continuously 1.
- Out-of-range select:
  - Stimulus: N=3, SEL_W=2, ctrl=3, all in_valid=1.
  - Response: in_ready=0, out_valid stays 0.
- Round-robin fairness (MUX_RR_EN defined):
  - Stimulus: mode=1; all 4 channels valid continuously; out_ready=1.
  - Response: out_sel sequence 0,1,2,3,0,1.
- Round-robin skip and reset:
  - Stimulus: in_valid=4'b1010 → grants 1,3,1.
  - Stimulus: assert rst mid-stream, then all channels valid.
  - Response: after reset, the first grant is 0.
